// File: rtl/pll_mdrp_responder.sv
// MDRP responder: register file with ID/STATUS/divider/scratch entries and lock emulation.
// Latency: READ data one cycle after the sampling edge; writes take effect at the sampling edge.
// Backpressure: none; one access is accepted every cycle.
module pll_mdrp_responder #(
   parameter int          ADDR_W      = 6,
   parameter int          LOCK_DELAY  = 64,
   parameter logic [7:0]  RESET_FBDIV = 8'd18
) (
   input  logic       mdclk,
   input  logic       reset,
   input  logic [1:0] mdopc,
   input  logic       mdainc,
   input  logic [7:0] mdwdi,
   output logic [7:0] mdrdo,
   output logic       lock,
   output logic [7:0] cfg_idiv,
   output logic [7:0] cfg_fbdiv,
   output logic [7:0] cfg_odiv,
   output logic       cfg_update
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam int CNT_W = (LOCK_DELAY > 2) ? $clog2(LOCK_DELAY) : 1;

   localparam logic [1:0] OPC_NOP   = 2'b00;
   localparam logic [1:0] OPC_WRITE = 2'b01;
   localparam logic [1:0] OPC_READ  = 2'b10;
   localparam logic [1:0] OPC_ADDR  = 2'b11;

   localparam logic [ADDR_W-1:0] A_ID     = ADDR_W'(0);
   localparam logic [ADDR_W-1:0] A_IDIV   = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] A_FBDIV  = ADDR_W'(2);
   localparam logic [ADDR_W-1:0] A_ODIV   = ADDR_W'(3);
   localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(4);
   localparam logic [7:0]        ID_VAL   = 8'h5A;

   typedef enum logic {ST_RELOCK, ST_LOCKED} state_t;

   logic [7:0]        r_regs [DEPTH];
   logic [ADDR_W-1:0] r_ptr;
   logic [7:0]        r_rdo;
   logic              r_cfg_update;
   state_t            r_state;
   state_t            w_state_nxt;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic              w_wr;
   logic              w_wr_keep;
   logic              w_div_wr;
   logic [7:0]        w_rd_dat;

   assign w_wr      = (mdopc == OPC_WRITE);
   // ID and STATUS are synthesised on read, so writes to them are discarded
   assign w_wr_keep = w_wr && (r_ptr != A_ID) && (r_ptr != A_STATUS);
   assign w_div_wr  = w_wr && ((r_ptr == A_IDIV) || (r_ptr == A_FBDIV) || (r_ptr == A_ODIV));

   // Register file: reset to the map defaults, store accepted writes
   always_ff @(posedge mdclk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
         r_regs[A_IDIV]  <= 8'd1;
         r_regs[A_FBDIV] <= RESET_FBDIV;
         r_regs[A_ODIV]  <= 8'd1;
      end else if (w_wr_keep) begin
         r_regs[r_ptr] <= mdwdi;
      end
   end

   // Address pointer: load on ADDR, otherwise optional post-increment (wraps naturally)
   always_ff @(posedge mdclk) begin
      if (reset) begin
         r_ptr <= '0;
      end else if (mdopc == OPC_ADDR) begin
         r_ptr <= mdwdi[ADDR_W-1:0];
      end else if (mdainc) begin
         r_ptr <= r_ptr + ADDR_W'(1);
      end
   end

   // Read mux: ID constant, STATUS reflects current lock, everything else from the file
   always_comb begin
      w_rd_dat = r_regs[r_ptr];
      if (r_ptr == A_ID)     w_rd_dat = ID_VAL;
      if (r_ptr == A_STATUS) w_rd_dat = {7'd0, lock};
   end

   // Read data register holds until the next READ; update strobe follows divider writes
   always_ff @(posedge mdclk) begin
      if (reset) begin
         r_rdo        <= '0;
         r_cfg_update <= 1'b0;
      end else begin
         if (mdopc == OPC_READ) r_rdo <= w_rd_dat;
         r_cfg_update <= w_div_wr;
      end
   end

   // Lock FSM state and settle counter
   always_ff @(posedge mdclk) begin
      if (reset) begin
         r_state <= ST_RELOCK;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Lock FSM next state: any divider write restarts the settle window from zero
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         ST_RELOCK: begin
            if (w_div_wr) begin
               w_cnt_nxt = '0;
            end else if (r_cnt == CNT_W'(LOCK_DELAY - 1)) begin
               w_state_nxt = ST_LOCKED;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         ST_LOCKED: begin
            if (w_div_wr) begin
               w_state_nxt = ST_RELOCK;
               w_cnt_nxt   = '0;
            end
         end
         default: begin
            w_state_nxt = ST_RELOCK;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   assign mdrdo      = r_rdo;
   assign lock       = (r_state == ST_LOCKED);
   assign cfg_update = r_cfg_update;
   assign cfg_idiv   = r_regs[A_IDIV];
   assign cfg_fbdiv  = r_regs[A_FBDIV];
   assign cfg_odiv   = r_regs[A_ODIV];

endmodule

// File: doc/pll_mdrp_responder.md
# pll_mdrp_responder

Responder end of the PLL dynamic-reconfiguration (MDRP) port: it accepts the 2-bit opcode / address-increment / 8-bit write-data stream that the PLL initialisation logic drives, and serves an 8-bit register file from it. It holds the divider configuration, returns read data on `mdrdo`, and runs a lock-emulation state machine that drops `lock` for a fixed settle time after reset and after every divider change. It is used as a soft PLL-control target and as the bench-side responder for the MDRP initiator.

## Interface
- `ADDR_W`, 6: register address width; the file has 2^ADDR_W entries.
- `LOCK_DELAY`, 64: cycles `lock` stays low after reset or after a divider write (≥2).
- `RESET_FBDIV`, 8'd18: reset value of the FBDIV register.
- `mdclk`  in  1  single clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `mdopc`  in  2  opcode: 00 NOP, 01 WRITE, 10 READ, 11 ADDR (load address).
- `mdainc`  in  1  post-increment the address after this cycle's access.
- `mdwdi`  in  8  write data; for ADDR, the low ADDR_W bits are the address.
- `mdrdo`  out  8  registered read data.
- `lock`  out  1  emulated PLL lock.
- `cfg_idiv`, `cfg_fbdiv`, `cfg_odiv`  out  8 each  current divider registers.
- `cfg_update`  out  1  one-cycle pulse after any divider write.

## Operation
- Register map:
  - 0x00 ID, read-only, 8'h5A.
  - 0x01 IDIV, reset 8'd1.
  - 0x02 FBDIV, reset RESET_FBDIV.
  - 0x03 ODIV, reset 8'd1.
  - 0x04 STATUS, read-only: bit0 = `lock`, bits 7:1 = 0.
  - 0x05 and up: scratch registers, reset 0.
- Address pointer: ADDR_W bits, reset 0.
- ADDR: the pointer loads `mdwdi[ADDR_W-1:0]` and `mdainc` is ignored.
- WRITE: stores `mdwdi` at the pointer. Writes to 0x00 and 0x04 are dropped silently.
- READ: captures the pointed register into `mdrdo`.
- NOP: no access.
- `mdainc`=1 with NOP, READ or WRITE increments the pointer after the access. The pointer wraps from 2^ADDR_W−1 to 0.
- `mdrdo` holds its value until the next READ.
- Lock FSM, two states:
  - RELOCK: the counter counts up from 0. At count LOCK_DELAY−1 the FSM goes to LOCKED.
  - LOCKED: `lock`=1. A write to 0x01–0x03 goes to RELOCK with the counter cleared.
  - A divider write while already in RELOCK restarts the counter at 0.
  - A write of an unchanged value still triggers RELOCK and `cfg_update`.
- Reset state: the FSM enters RELOCK.
- `cfg_*` outputs are the register contents directly, with no shadowing.

## Timing
- Reset values: `mdrdo`=0, `lock`=0, `cfg_update`=0, `cfg_idiv`=1, `cfg_fbdiv`=RESET_FBDIV, `cfg_odiv`=1, pointer=0, FSM=RELOCK with count 0.
- Reset mid-operation: everything returns to the reset values on the next edge. Any in-flight access is discarded.
- READ sampled at edge N → `mdrdo` valid after edge N (one-cycle latency), stable until the next READ.
- WRITE sampled at edge N:
  - The register, and `cfg_*` if a divider, update at edge N.
  - A READ of the same address at edge N+1 returns the new value.
- `cfg_update` is high for exactly the cycle after the divider write edge. Back-to-back divider writes keep it high on consecutive cycles.
- Divider write at edge N → `lock`=0 from edge N. `lock` returns to 1 at edge N+LOCK_DELAY if there is no further divider write.
- After reset deasserts at edge R, `lock` rises at edge R+LOCK_DELAY.
- Reading STATUS returns `lock` as it was before the read edge.
- Pointer update for an access with `mdainc` is visible to the next cycle's access (no bubble).

## Test plan
- Reset, then hold NOP: `lock`=0 for 64 cycles, then 1. READ 0x00 → `mdrdo`=8'h5A one cycle later. READ 0x02 → 8'd18.
- ADDR 0x05, then WRITE 0xA1, 0xA2, 0xA3 with `mdainc`=1; ADDR 0x05, then READ ×3 with `mdainc`=1 → 0xA1, 0xA2, 0xA3 on consecutive cycles.
- ADDR 0x3F, WRITE 0x77 with `mdainc`=1, then READ → pointer wrapped to 0, `mdrdo`=0x5A. ADDR 0x3F, READ → 0x77.
- While locked, ADDR 0x02, WRITE 0x24:
  - `cfg_fbdiv`=0x24.
  - `cfg_update` pulses for one cycle.
  - `lock` falls at the write edge and rises 64 cycles later.
  - READ 0x04 in between → 0x00.
- Divider write at cycle 0, second divider write at cycle 30 → `lock` rises at cycle 94. `cfg_update` pulses twice.
- WRITE 0xFF to 0x00 and to 0x04 → reads return 0x5A and the live lock bit. No `cfg_update`, `lock` unaffected.
- Assert `reset` mid-RELOCK after a scratch write → scratch reads back 0, the divider outputs return to their reset values, and `lock` needs a full 64 cycles again.
